// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC multichannel sampler.
package xadc_pkg;

  localparam int XADC_CODE_W = 12;

  // Well-known XADC DRP status register addresses
  localparam logic [6:0] ADDR_TEMP      = 7'h00;
  localparam logic [6:0] ADDR_VAUX_BASE = 7'h10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    ACC
  } state_t;

  // Millivolts for a 1 V full-scale range: (code * 1000) >> 12
  function automatic logic [9:0] mv_from_code(input logic [XADC_CODE_W-1:0] code);
    logic [21:0] prod;
    prod = 22'(code) * 22'd1000;
    return prod[21:12];
  endfunction

endpackage

// File: rtl/xadc_drp_reader.sv
// DRP read handshake: one-cycle den pulse, address hold, bounded wait for drdy.
module xadc_drp_reader
  import xadc_pkg::*;
#(
  parameter int TIMEOUT = 63
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [6:0]             i_addr,
  output logic                   o_done,
  output logic                   o_err,
  output logic [XADC_CODE_W-1:0] o_code,
  output logic                   o_den,
  output logic [6:0]             o_daddr,
  input  logic                   i_drdy,
  input  logic [XADC_CODE_W-1:0] i_drp_code
);

  localparam int                TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t                   r_state;
  logic [TMO_W-1:0]         r_tmo;
  logic                     r_den;
  logic [6:0]               r_daddr;
  logic [XADC_CODE_W-1:0]   r_code;

  // drdy wins over the timeout when both land on the last wait cycle
  assign o_done  = (r_state == WAIT) && i_drdy;
  assign o_err   = (r_state == WAIT) && !i_drdy && (r_tmo == TMO_LAST);
  assign o_code  = r_code;
  assign o_den   = r_den;
  assign o_daddr = r_daddr;

  // Request/wait sequencer with timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tmo   <= '0;
      r_den   <= 1'b0;
      r_daddr <= '0;
      r_code  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= REQ;
            r_den   <= 1'b1;
            r_daddr <= i_addr;
          end
        end
        REQ: begin
          r_state <= WAIT;
          r_den   <= 1'b0;
          r_tmo   <= '0;
        end
        WAIT: begin
          if (i_drdy) begin
            r_state <= IDLE;
            r_code  <= i_drp_code;
            r_daddr <= '0;
          end else if (r_tmo == TMO_LAST) begin
            r_state <= IDLE;
            r_daddr <= '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_den   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/xadc_multichannel_sampler.sv
// XADC sequencer front end: matches eoc channels, reads results over DRP,
// averages 2**AVG_LOG2 samples per channel and serves registered readback.
module xadc_multichannel_sampler
  import xadc_pkg::*;
#(
  parameter int               NUM_CH   = 4,
  // ch i = CH_ADDRS[7*i +: 7]; ch0 sits in the low bits (ch0=0x15 .. ch3=0x1E)
  parameter logic [7*NUM_CH-1:0] CH_ADDRS = {7'h1E, 7'h16, 7'h1C, 7'h15},
  parameter int               AVG_LOG2 = 2,
  parameter int               TIMEOUT  = 63,
  localparam int              SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             eoc_in,
  input  logic [4:0]       channel_in,
  output logic [6:0]       daddr_out,
  output logic             den_out,
  input  logic             drdy_in,
  input  logic [15:0]      do_in,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [11:0]      rd_code,
  output logic [9:0]       rd_mv,
  output logic             rd_valid,
  output logic             sample_strobe,
  output logic             overrun,
  output logic             drp_err
);

  localparam int                ACC_W    = XADC_CODE_W + AVG_LOG2;
  localparam int                CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  state_t                  r_state;
  logic [SEL_W-1:0]        r_k;
  logic                    r_overrun;
  logic                    r_drp_err;

  logic [ACC_W-1:0]        r_acc   [NUM_CH];
  logic [CNT_W-1:0]        r_cnt   [NUM_CH];
  logic [XADC_CODE_W-1:0]  r_avg   [NUM_CH];
  logic [NUM_CH-1:0]       r_valid;
  logic                    r_strobe;

  logic [XADC_CODE_W-1:0]  r_rd_code;
  logic [9:0]              r_rd_mv;
  logic                    r_rd_valid;

  logic                    w_match;
  logic [SEL_W-1:0]        w_k;
  logic [6:0]              w_addr;
  logic                    w_start;
  logic                    w_done;
  logic                    w_err;
  logic [XADC_CODE_W-1:0]  w_code;
  logic [ACC_W-1:0]        w_acc_new;
  logic                    w_sel_ok;
  logic                    w_unused_lsb;

  assign w_unused_lsb = ^do_in[3:0];

  // Channel match: first CH_ADDRS entry equal to the zero-extended channel wins
  always_comb begin
    w_match = 1'b0;
    w_k     = '0;
    w_addr  = {2'b00, channel_in};
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!w_match && (CH_ADDRS[7*i +: 7] == w_addr)) begin
        w_match = 1'b1;
        w_k     = SEL_W'(i);
      end
    end
  end

  assign w_start = (r_state == IDLE) && eoc_in && w_match;

  xadc_drp_reader #(
    .TIMEOUT (TIMEOUT)
  ) u_drp (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_start    (w_start),
    .i_addr     (w_addr),
    .o_done     (w_done),
    .o_err      (w_err),
    .o_code     (w_code),
    .o_den      (den_out),
    .o_daddr    (daddr_out),
    .i_drdy     (drdy_in),
    .i_drp_code (do_in[15:4])
  );

  // Sequencer tracking plus sticky overrun / DRP-error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_overrun <= 1'b0;
      r_drp_err <= 1'b0;
    end else begin
      if (eoc_in && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= REQ;
            r_k     <= w_k;
          end
        end
        REQ:  r_state <= WAIT;
        WAIT: begin
          if (w_done) begin
            r_state <= ACC;
          end else if (w_err) begin
            r_state   <= IDLE;
            r_drp_err <= 1'b1;
          end
        end
        ACC:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_acc_new = r_acc[r_k] + ACC_W'(w_code);

  // Per-channel accumulate; publish the truncated average when the count wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
        r_avg[i] <= '0;
      end
      r_valid  <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      if (r_state == ACC) begin
        if (r_cnt[r_k] == CNT_LAST) begin
          r_cnt[r_k]   <= '0;
          r_acc[r_k]   <= '0;
          r_avg[r_k]   <= w_acc_new[AVG_LOG2 +: XADC_CODE_W];
          r_valid[r_k] <= 1'b1;
          r_strobe     <= 1'b1;
        end else begin
          r_cnt[r_k] <= r_cnt[r_k] + 1'b1;
          r_acc[r_k] <= w_acc_new;
        end
      end
    end
  end

  assign w_sel_ok = (32'(rd_sel) < 32'(NUM_CH));

  // Registered readback; same-cycle updates are seen one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_code  <= '0;
      r_rd_mv    <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_sel_ok) begin
      r_rd_code  <= r_avg[rd_sel];
      r_rd_mv    <= mv_from_code(r_avg[rd_sel]);
      r_rd_valid <= r_valid[rd_sel];
    end else begin
      r_rd_code  <= '0;
      r_rd_mv    <= '0;
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_code       = r_rd_code;
  assign rd_mv         = r_rd_mv;
  assign rd_valid      = r_rd_valid;
  assign sample_strobe = r_strobe;
  assign overrun       = r_overrun;
  assign drp_err       = r_drp_err;

endmodule

// File: tb/tb_xadc_multichannel_sampler.sv
// Bench for xadc_multichannel_sampler: directed DRP transactions, a per-channel
// averaging model compared every cycle, plus literal spot checks.
module tb_xadc_multichannel_sampler;

  localparam int NSAMP = 4;

  logic        clk;
  logic        reset_n;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic [6:0]  daddr_out;
  logic        den_out;
  logic        drdy_in;
  logic [15:0] do_in;
  logic [1:0]  rd_sel;
  logic [11:0] rd_code;
  logic [9:0]  rd_mv;
  logic        rd_valid;
  logic        sample_strobe;
  logic        overrun;
  logic        drp_err;

  xadc_multichannel_sampler #(
    .NUM_CH   (4),
    .AVG_LOG2 (2),
    .TIMEOUT  (63)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .eoc_in        (eoc_in),
    .channel_in    (channel_in),
    .daddr_out     (daddr_out),
    .den_out       (den_out),
    .drdy_in       (drdy_in),
    .do_in         (do_in),
    .rd_sel        (rd_sel),
    .rd_code       (rd_code),
    .rd_mv         (rd_mv),
    .rd_valid      (rd_valid),
    .sample_strobe (sample_strobe),
    .overrun       (overrun),
    .drp_err       (drp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;
  int n_strobe = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int due;
    int ch;
    int code;
  } pend_t;

  pend_t pend[$];
  int    m_sum   [4];
  int    m_n     [4];
  int    m_avg   [4];
  int    m_valid [4];
  int    m_overrun = 0;
  int    m_drp_err = 0;
  int    exp_den_cyc = -1;
  int    exp_addr = 0;
  int    snap_code = 0;
  int    snap_mv = 0;
  int    snap_valid = 0;

  function automatic int ch_index(input logic [4:0] ch);
    case (ch)
      5'h15:   return 0;
      5'h1C:   return 1;
      5'h16:   return 2;
      5'h1E:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int mv_of(input int code);
    return (code * 1000) / 4096;
  endfunction

  // Compare process: DUT outputs versus the model on every falling edge
  always @(negedge clk) begin
    int exp_strobe;
    pend_t pe;
    if (!reset_n) begin
      check("rst_den", den_out, 0);
      check("rst_daddr", daddr_out, 0);
      check("rst_code", rd_code, 0);
      check("rst_mv", rd_mv, 0);
      check("rst_valid", rd_valid, 0);
      check("rst_strobe", sample_strobe, 0);
      check("rst_overrun", overrun, 0);
      check("rst_drp_err", drp_err, 0);
      pend.delete();
      for (int i = 0; i < 4; i++) begin
        m_sum[i] = 0; m_n[i] = 0; m_avg[i] = 0; m_valid[i] = 0;
      end
      m_overrun = 0; m_drp_err = 0;
      snap_code = 0; snap_mv = 0; snap_valid = 0;
    end else begin
      exp_strobe = 0;
      while (pend.size() > 0 && pend[0].due <= cyc) begin
        pe = pend.pop_front();
        m_sum[pe.ch] += pe.code;
        m_n[pe.ch]++;
        if (m_n[pe.ch] == NSAMP) begin
          m_avg[pe.ch]   = m_sum[pe.ch] / NSAMP;
          m_valid[pe.ch] = 1;
          m_sum[pe.ch]   = 0;
          m_n[pe.ch]     = 0;
          exp_strobe     = 1;
        end
      end
      if (sample_strobe) n_strobe++;
      check("strobe", sample_strobe, exp_strobe);
      check("rd_code", rd_code, snap_code);
      check("rd_mv", rd_mv, snap_mv);
      check("rd_valid", rd_valid, snap_valid);
      check("overrun", overrun, m_overrun);
      check("drp_err", drp_err, m_drp_err);
      check("den", den_out, (cyc == exp_den_cyc) ? 1 : 0);
      if (cyc == exp_den_cyc) check("daddr", daddr_out, exp_addr);
      snap_code  = m_avg[rd_sel];
      snap_mv    = mv_of(m_avg[rd_sel]);
      snap_valid = m_valid[rd_sel];
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One DRP transaction: eoc, lat extra WAIT cycles, drdy with code.
  // dup: repeat eoc in the REQ cycle; acc_eoc: send eoc in the ACC cycle.
  task automatic do_read(input logic [4:0] ch, input int code, input int lat,
                         input bit dup, input bit acc_eoc);
    logic [11:0] c12;
    int k;
    k = ch_index(ch);
    c12 = 12'(code);
    eoc_in = 1'b1; channel_in = ch;
    exp_den_cyc = cyc + 1;
    exp_addr = int'({2'b00, ch});
    tick();
    eoc_in = dup;
    tick();
    eoc_in = 1'b0;
    if (dup) m_overrun = 1;
    repeat (lat) tick();
    drdy_in = 1'b1; do_in = {c12, 4'hA};
    pend.push_back('{due: cyc + 2, ch: k, code: code});
    tick();
    drdy_in = 1'b0; do_in = '0;
    eoc_in = acc_eoc;
    tick();
    eoc_in = 1'b0;
    if (acc_eoc) m_overrun = 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic check_rd(input string tag, input int sel, input int code,
                          input int mv, input int valid);
    rd_sel = 2'(sel);
    tick();
    tick();
    check({tag, "_code"}, rd_code, code);
    check({tag, "_mv"}, rd_mv, mv);
    check({tag, "_valid"}, rd_valid, valid);
  endtask

  int t2_codes [4] = '{1, 2, 3, 4};
  int t4_codes [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
  int t6_codes [4][4] = '{'{12'h010, 12'h020, 12'h030, 12'h041},
                          '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF},
                          '{12'h000, 12'h001, 12'h002, 12'h000},
                          '{12'h400, 12'h401, 12'h402, 12'h403}};
  int t6_avg [4] = '{12'h028, 12'hFFF, 12'h000, 12'h401};
  int t6_mv  [4] = '{9, 999, 0, 250};
  logic [4:0] addr_tab [4] = '{5'h15, 5'h1C, 5'h16, 5'h1E};

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; eoc_in = 1'b0; channel_in = '0;
    drdy_in = 1'b0; do_in = '0; rd_sel = '0;
    tick(); tick(); tick();
    check("reset_den", den_out, 0);
    check("reset_daddr", daddr_out, 0);
    check("reset_code", rd_code, 0);
    check("reset_mv", rd_mv, 0);
    check("reset_valid", rd_valid, 0);
    check("reset_strobe", sample_strobe, 0);
    check("reset_overrun", overrun, 0);
    check("reset_drp_err", drp_err, 0);
    reset_n = 1'b1;
    tick();

    // 1: four 0x800 samples on 0x15
    for (int i = 0; i < 4; i++) do_read(5'h15, 12'h800, i, 1'b0, 1'b0);
    check_rd("t1", 0, 12'h800, 500, 1);
    check("t1_strobes", n_strobe, 1);

    // 2: truncating average
    for (int i = 0; i < 4; i++) do_read(5'h1C, t2_codes[i], 1, 1'b0, 1'b0);
    check_rd("t2", 1, 12'h002, 0, 1);

    // 3: unlisted channel ignored
    eoc_in = 1'b1; channel_in = 5'h03;
    tick();
    eoc_in = 1'b0;
    repeat (4) tick();
    check("t3_overrun", overrun, 0);
    check("t3_drp_err", drp_err, 0);
    check("t3_strobes", n_strobe, 2);

    // 4: eoc during REQ -> overrun, only one sample counted
    do_read(5'h16, t4_codes[0], 3, 1'b1, 1'b0);
    check("t4_overrun", overrun, 1);
    for (int i = 1; i < 4; i++) do_read(5'h16, t4_codes[i], 2, 1'b0, 1'b0);
    check_rd("t4", 2, 12'h5EF, 370, 1);

    // 5: no drdy -> timeout after 63 WAIT cycles, then normal service
    eoc_in = 1'b1; channel_in = 5'h1E;
    exp_den_cyc = cyc + 1; exp_addr = 7'h1E;
    tick();
    eoc_in = 1'b0;
    tick();
    repeat (62) tick();
    check("t5_err_before", drp_err, 0);
    tick();
    m_drp_err = 1;
    check("t5_err_after", drp_err, 1);
    do_read(5'h1E, 12'h100, 0, 1'b0, 1'b0);

    // 6: interleaved channels after a clean reset
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        do_read(addr_tab[c], t6_codes[c][r], (r + c) % 3, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) check_rd("t6", c, t6_avg[c], t6_mv[c], 1);

    // reset mid-WAIT, then a late drdy that must be ignored
    eoc_in = 1'b1; channel_in = 5'h15;
    exp_den_cyc = cyc + 1; exp_addr = 7'h15;
    tick();
    eoc_in = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("t6_rst_daddr", daddr_out, 0);
    check("t6_rst_den", den_out, 0);
    check("t6_rst_code", rd_code, 0);
    check("t6_rst_mv", rd_mv, 0);
    check("t6_rst_valid", rd_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    drdy_in = 1'b1; do_in = 16'hFFF0;
    tick();
    drdy_in = 1'b0; do_in = '0;
    repeat (4) tick();
    check("t6_late_den", den_out, 0);

    // 7: eoc in the ACC cycle is dropped and flags overrun
    do_read(5'h15, 12'h300, 1, 1'b0, 1'b1);
    check("t7_overrun", overrun, 1);
    do_read(5'h15, 12'h300, 0, 1'b0, 1'b0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
